eqed_lfsr_stim_gen: RTL

- Pseudo-random stimulus generator: the transmit-side counterpart of the E-QED input/output MISR signature compactors.
- Drives a design-under-check's primary inputs from a Fibonacci LFSR for a programmed number of cycles, then signals completion so the signature window can close.
- Sits in the top-level E-QED wrapper between the run controller and the DUT inputs that feed the input MISR.

---
 rtl/eqed_lfsr_stim_gen_if.sv | 34 +++
 rtl/eqed_lfsr_stim_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/eqed_lfsr_stim_gen_if.sv
// ---------------------------------------------------------------------------
// eqed_lfsr_stim_gen_if
// Bundles the run-control request and the stimulus/status response of the
// E-QED LFSR stimulus generator.
//   master : run controller side (drives start/seed/num_cycles/stall)
//   slave  : generator side (drives pat_out/pat_valid/busy/done/cycle_idx/
//            lfsr_state)
// ---------------------------------------------------------------------------
interface eqed_lfsr_stim_gen_if #(
  parameter int WIDTH = 6,
  parameter int NOUT  = 2,
  parameter int CNT_W = 10
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] num_cycles;
  logic             stall;
  logic [NOUT-1:0]  pat_out;
  logic             pat_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_idx;
  logic [WIDTH-1:0] lfsr_state;

  modport master (
    output start, seed, num_cycles, stall,
    input  pat_out, pat_valid, busy, done, cycle_idx, lfsr_state
  );

  modport slave (
    input  start, seed, num_cycles, stall,
    output pat_out, pat_valid, busy, done, cycle_idx, lfsr_state
  );
endinterface

// File: rtl/eqed_lfsr_stim_gen.sv
// ---------------------------------------------------------------------------
// eqed_lfsr_stim_gen
// Pseudo-random stimulus generator feeding the DUT primary inputs that the
// E-QED input MISR compacts. A Fibonacci LFSR is seeded on start and stepped
// once per unstalled cycle for num_cycles patterns, after which done pulses
// for one cycle so the signature window can close.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low
//   bus  : eqed_lfsr_stim_gen_if.slave
//            start/seed/num_cycles : run request, sampled only in IDLE
//            stall                 : hold the current pattern
//            pat_out/pat_valid     : stimulus bits (top LFSR bits, MSB first)
//            busy/done             : run status
//            cycle_idx             : patterns emitted so far in this run
//            lfsr_state            : LFSR contents for observability
// ---------------------------------------------------------------------------
module eqed_lfsr_stim_gen #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = 6'b110000,
  parameter int               NOUT  = 2,
  parameter int               CNT_W = 10
) (
  input logic                 clk,
  input logic                 rst,
  eqed_lfsr_stim_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             in_run;

  // Shift toward the MSB; the tapped bits fold back into bit 0.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    return {s[WIDTH-2:0], fb};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_ONE;
      idx_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    num_d   = num_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // An all-zero seed would lock the LFSR at zero forever.
          lfsr_d  = (bus.seed == '0) ? LFSR_ONE : bus.seed;
          num_d   = bus.num_cycles;
          idx_d   = '0;
          state_d = (bus.num_cycles == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          lfsr_d = lfsr_step(lfsr_q);
          idx_d  = idx_q + CNT_W'(1);
          // num_q is nonzero whenever RUN is entered, so num_q-1 never wraps.
          if (idx_q == num_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_run         = (state_q == S_RUN);
  assign bus.busy       = in_run;
  assign bus.done       = (state_q == S_DONE);
  assign bus.pat_valid  = in_run & ~bus.stall;
  assign bus.cycle_idx  = idx_q;
  assign bus.lfsr_state = lfsr_q;

  // pat_out[k] taps the LFSR from the MSB downward and is forced low
  // outside RUN.
  for (genvar k = 0; k < NOUT; k++) begin : g_pat
    assign bus.pat_out[k] = in_run & lfsr_q[WIDTH-1-k];
  end

endmodule
